// File: rtl/multicycle_data_mem.sv
// Byte-addressed big-endian data memory with req/done handshake and MEM_LAT-cycle access.
// Faulting accesses (misaligned, reserved size, past the end) finish in one cycle without touching the array.
module multicycle_data_mem #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32,
  parameter int MEM_LAT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        num_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_addr_o,
  output logic              err_mis_o
);

  localparam int IW = $clog2(MEM_BYTES);
  localparam int EW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]             cnt;
  logic                   we_q, uns_q;
  logic [1:0]             num_q;
  logic [IW-1:0]          idx_q;
  logic [31:0]            wdata_q;
  logic [MEM_BYTES-1:0][7:0] mem;

  // Fault decode works on the full-width live address so high addresses never wrap into range
  logic [2:0]  nbytes_i;
  logic [EW-1:0] end_i;
  logic        mis_i, ovf_i, fault_i, accept;

  always_comb begin
    nbytes_i = (num_i == 2'b00) ? 3'd1 : (num_i == 2'b01) ? 3'd2 : 3'd4;
    mis_i    = (num_i == 2'b01 && addr_i[0]) || (num_i == 2'b10 && addr_i[1:0] != 2'b00) ||
               (num_i == 2'b11);
    end_i    = {1'b0, addr_i} + EW'(nbytes_i);
    ovf_i    = end_i > EW'(MEM_BYTES);
    fault_i  = mis_i | ovf_i;
    accept   = (state == IDLE) && req_i;
  end

  // With MEM_LAT=1 the access happens on the accept edge, so it must use the live inputs
  logic          acc_we, acc_uns, do_access;
  logic [1:0]    acc_num;
  logic [2:0]    acc_nb;
  logic [IW-1:0] acc_idx;
  logic [31:0]   acc_wd, ld_val;
  logic [7:0]    rb [4];

  always_comb begin
    acc_we  = (state == IDLE) ? we_i         : we_q;
    acc_uns = (state == IDLE) ? unsigned_i   : uns_q;
    acc_num = (state == IDLE) ? num_i        : num_q;
    acc_idx = (state == IDLE) ? addr_i[IW-1:0] : idx_q;
    acc_wd  = (state == IDLE) ? wdata_i      : wdata_q;
    acc_nb  = (acc_num == 2'b00) ? 3'd1 : (acc_num == 2'b01) ? 3'd2 : 3'd4;
    do_access = (accept && !fault_i && MEM_LAT == 1) || (state == WAIT && cnt == 4'd1);
    for (int i = 0; i < 4; i++) rb[i] = mem[acc_idx + IW'(i)];
    case (acc_num)
      2'b00:   ld_val = acc_uns ? {24'h0, rb[0]} : {{24{rb[0][7]}}, rb[0]};
      2'b01:   ld_val = acc_uns ? {16'h0, rb[0], rb[1]} : {{16{rb[0][7]}}, rb[0], rb[1]};
      default: ld_val = {rb[0], rb[1], rb[2], rb[3]};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = (fault_i || MEM_LAT == 1) ? DONE : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == WAIT);
    done_o = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      num_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_o    <= '0;
      err_addr_o <= 1'b0;
      err_mis_o  <= 1'b0;
      mem        <= '0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        num_q   <= num_i;
        idx_q   <= addr_i[IW-1:0];
        wdata_q <= wdata_i;
        cnt     <= 4'(MEM_LAT - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (accept && fault_i) begin
        rdata_o    <= '0;
        err_addr_o <= ovf_i;
        err_mis_o  <= mis_i;
      end else if (do_access) begin
        rdata_o    <= acc_we ? 32'h0 : ld_val;
        err_addr_o <= 1'b0;
        err_mis_o  <= 1'b0;
        if (acc_we)
          for (int i = 0; i < 4; i++)
            if (i < int'(acc_nb))
              mem[acc_idx + IW'(i)] <= acc_wd[8*(int'(acc_nb)-1-i) +: 8];
      end
    end
  end

endmodule
